// File: rtl/load_store_unit.sv
// Load/store unit that sits between the core and a word-wide data memory.
// Sub-word stores are done as read-modify-write, loads are lane-selected and
// extended, and illegal accesses are answered at once with a fault pulse.
module load_store_unit #(
  parameter logic [31:0] DM_BASE = 32'h6600_0000,
  parameter logic [31:0] DM_LAST = 32'h6600_00FC
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        fault_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [31:0] wd_q;       // store data; replaced by the merged word in RMW
  logic [31:0] rd_q;
  logic [31:0] mem_addr_q;
  logic        ready_q;
  logic        fault_q;

  logic [31:0] aligned_addr;
  logic        reject;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Legality of the incoming request: size code, alignment, address window.
  always_comb begin
    // NOTE: every signal assigned here gets a value before any branch, so no latch is inferred.
    aligned_addr = {addr_i[31:2], 2'b00};
    reject       = 1'b0;
    if (size_i == 2'b11)                            reject = 1'b1;
    if (size_i == SZ_HALF && addr_i[0])             reject = 1'b1;
    if (size_i == SZ_WORD && addr_i[1:0] != 2'b00)  reject = 1'b1;
    if (aligned_addr < DM_BASE || aligned_addr > DM_LAST) reject = 1'b1;
  end

  // Lane selection with extension for loads, lane merge for sub-word stores.
  always_comb begin
    load_val = mem_rd_i;
    merged   = mem_rd_i;
    case (size_q)
      SZ_BYTE: begin
        load_val = {{24{~uns_q & mem_rd_i[{off_q, 3'b111}]}},
                    mem_rd_i[{off_q, 3'b000} +: 8]};
        merged[{off_q, 3'b000} +: 8] = wd_q[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{~uns_q & mem_rd_i[{off_q[1], 4'b1111}]}},
                    mem_rd_i[{off_q[1], 4'b0000} +: 16]};
        merged[{off_q[1], 4'b0000} +: 16] = wd_q[15:0];
      end
      default: begin
        load_val = mem_rd_i;
        merged   = wd_q;
      end
    endcase
  end

  // Access sequencer: accept in IDLE, read in RD, write in WR; pulses ready/fault.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wd_q       <= '0;
      rd_q       <= '0;
      mem_addr_q <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            mem_addr_q <= aligned_addr;
            off_q      <= addr_i[1:0];
            size_q     <= size_i;
            we_q       <= we_i;
            uns_q      <= unsigned_i;
            wd_q       <= wd_i;
            if (reject) begin
              ready_q <= 1'b1;
              fault_q <= 1'b1;
            end else if (we_i && size_i == SZ_WORD) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            wd_q    <= merged;
            state_q <= WR;
          end else begin
            rd_q    <= load_val;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        WR: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes follow the state register, so reset kills a write at once.
  assign mem_we_o   = (state_q == WR);
  assign mem_wd_o   = mem_we_o ? wd_q : '0;
  assign mem_addr_o = mem_addr_q;
  assign busy_o     = (state_q != IDLE);
  assign rd_o       = rd_q;
  assign ready_o    = ready_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic against a byte-addressed reference memory model.
module tb_load_store_unit;

  localparam logic [31:0] DM_BASE = 32'h6600_0000;
  localparam logic [31:0] DM_LAST = 32'h6600_00FC;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wd_i;
  logic [31:0] rd_o;
  logic        ready_o;
  logic        busy_o;
  logic        fault_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic        mem_we_o;
  logic [31:0] mem_rd_i;

  load_store_unit #(.DM_BASE(DM_BASE), .DM_LAST(DM_LAST)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wd_i(wd_i),
    .rd_o(rd_o), .ready_o(ready_o), .busy_o(busy_o), .fault_o(fault_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_we_o(mem_we_o),
    .mem_rd_i(mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory the DUT talks to.
  logic [31:0] dmem [64];
  logic [31:0] last_wd = '0;
  int          wr_count = 0;
  assign mem_rd_i = dmem[mem_addr_o[7:2]];

  always @(posedge clk_i) begin
    if (mem_we_o) begin
      dmem[mem_addr_o[7:2]] <= mem_wd_o;
      last_wd               <= mem_wd_o;
      wr_count              <= wr_count + 1;
    end
  end

  // Reference model: flat byte array plus the value rd_o should hold.
  logic [7:0]  ref_bytes [256];
  logic [31:0] exp_rd;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(input int off);
    int wo;
    wo = off & ~3;
    return {ref_bytes[wo+3], ref_bytes[wo+2], ref_bytes[wo+1], ref_bytes[wo]};
  endfunction

  task automatic idle_cycle();
    @(negedge clk_i);
    check("idle ready", {31'd0, ready_o}, 32'd0);
    check("idle busy",  {31'd0, busy_o},  32'd0);
  endtask

  // One transaction starting at a negedge; returns at the negedge where ready_o is seen.
  task automatic access(input string tag, input bit we, input logic [1:0] sz,
                        input bit uns, input logic [31:0] a, input logic [31:0] wd,
                        input bit hold);
    bit          rej;
    int          nb, off, lat, exp_lat, wr0;
    logic [31:0] aligned, v;
    aligned = a & ~32'd3;
    rej = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
          (aligned < DM_BASE) || (aligned > DM_LAST);
    nb  = 1 << sz;
    off = int'(a - DM_BASE);
    exp_lat = rej ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
    wr0 = wr_count;
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wd_i = wd;
    @(posedge clk_i);
    #1;
    if (!hold) req_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
      if (lat == 1) check({tag, " busy"}, {31'd0, busy_o}, {31'd0, !rej});
    end while (!ready_o && lat < 8);
    check({tag, " ready"},   {31'd0, ready_o}, 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " fault"},   {31'd0, fault_o}, {31'd0, rej});
    check({tag, " writes"},  wr_count - wr0, (we && !rej) ? 1 : 0);
    if (!rej) begin
      check({tag, " mem_addr"}, mem_addr_o, aligned);
      if (we) begin
        for (int i = 0; i < nb; i++) ref_bytes[off+i] = wd[8*i +: 8];
        check({tag, " wdata"}, last_wd, ref_word(off));
        check({tag, " dmem"},  dmem[off/4], ref_word(off));
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v |= 32'(ref_bytes[off+i]) << (8*i);
        if (!uns && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8*nb)) - 32'd1);
        exp_rd = v;
      end
    end
    check({tag, " rd"}, rd_o, exp_rd);
  endtask

  initial begin
    int          wr0;
    logic [31:0] a;
    logic [1:0]  sz;
    rstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00;
    unsigned_i = 1'b0; addr_i = '0; wd_i = '0;
    exp_rd = '0;
    for (int w = 0; w < 64; w++) begin
      dmem[w] = $urandom;
      for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = dmem[w][8*i +: 8];
    end
    #1;
    check("reset rd",     rd_o, 32'd0);
    check("reset flags",  {29'd0, ready_o, busy_o, fault_o}, 32'd0);
    check("reset maddr",  mem_addr_o, 32'd0);
    check("reset mwd",    {mem_wd_o[31:1], mem_wd_o[0] | mem_we_o}, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rstn_i = 1'b1;
    idle_cycle();

    // Word store then load back.
    access("sw",  1, 2'd2, 0, 32'h6600_0010, 32'hDEAD_BEEF, 0);
    access("lw",  0, 2'd2, 0, 32'h6600_0010, 32'h0, 0);
    check("lw value", rd_o, 32'hDEAD_BEEF);
    // Byte store by read-modify-write, then signed/unsigned byte loads.
    access("sb",  1, 2'd0, 0, 32'h6600_0011, 32'h0000_00A5, 0);
    check("sb merged", last_wd, 32'hDEAD_A5EF);
    access("lb",  0, 2'd0, 0, 32'h6600_0011, 32'h0, 0);
    check("lb value", rd_o, 32'hFFFF_FFA5);
    access("lbu", 0, 2'd0, 1, 32'h6600_0011, 32'h0, 0);
    check("lbu value", rd_o, 32'h0000_00A5);
    access("lh",  0, 2'd1, 0, 32'h6600_0012, 32'h0, 0);
    check("lh value", rd_o, 32'hFFFF_DEAD);
    access("lhu", 0, 2'd1, 1, 32'h6600_0012, 32'h0, 0);
    check("lhu value", rd_o, 32'h0000_DEAD);
    // Rejected accesses: misaligned word, out of window, illegal size.
    access("rej misalign", 0, 2'd2, 0, 32'h6600_0002, 32'h0, 0);
    access("rej range",    0, 2'd2, 0, 32'h6600_0100, 32'h0, 0);
    access("rej size",     0, 2'd3, 0, 32'h6600_0000, 32'h0, 0);
    access("rej below",    1, 2'd2, 0, 32'h65FF_FFFC, 32'h1234_5678, 0);
    check("rej rd kept", rd_o, 32'h0000_DEAD);
    idle_cycle();
    // Window edges.
    access("sw last", 1, 2'd2, 0, 32'h6600_00FC, 32'h0102_0304, 0);
    access("sb last", 1, 2'd0, 0, 32'h6600_00FF, 32'h0000_0080, 0);
    access("lw last", 0, 2'd2, 0, 32'h6600_00FC, 32'h0, 0);
    check("lw last value", rd_o, 32'h8002_0304);
    access("lb base", 0, 2'd0, 1, 32'h6600_0000, 32'h0, 0);

    // req_i held high across sub-word stores: back-to-back acceptance.
    access("hold sh0", 1, 2'd1, 0, 32'h6600_0030, 32'h0000_BEEF, 1);
    access("hold sh1", 1, 2'd1, 0, 32'h6600_0032, 32'h0000_CAFE, 1);
    access("hold lw",  0, 2'd2, 0, 32'h6600_0030, 32'h0, 0);
    check("hold value", rd_o, 32'hCAFE_BEEF);

    // Reset while a half store is in its write cycle.
    wr0 = wr_count;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd1; unsigned_i = 1'b0;
    addr_i = 32'h6600_0022; wd_i = 32'h0000_1234;
    @(posedge clk_i); #1; req_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst wr we", {31'd0, mem_we_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    check("rst we drop", {31'd0, mem_we_o}, 32'd0);
    check("rst flags",   {29'd0, ready_o, busy_o, fault_o}, 32'd0);
    check("rst rd",      rd_o, 32'd0);
    check("rst maddr",   mem_addr_o, 32'd0);
    check("rst mwd",     mem_wd_o, 32'd0);
    exp_rd = '0;
    @(negedge clk_i); @(negedge clk_i);
    check("rst no write", wr_count - wr0, 0);
    rstn_i = 1'b1;
    access("rst readback", 0, 2'd2, 0, 32'h6600_0020, 32'h0, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       a = DM_BASE + 32'h100 + 32'($urandom_range(0, 64));
        1:       a = DM_BASE - 32'($urandom_range(1, 8));
        default: a = DM_BASE + 32'($urandom_range(0, 255));
      endcase
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      access("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        req_i = 1'b0;
        @(negedge clk_i);
      end
    end
    req_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
